// File: rtl/controlador_buffer_pantalla.sv
// controlador_buffer_pantalla: owns the displayed 'numeros' register. It queues
// keypad events and ALU results, and applies them only during vertical blanking
// so that the screen never shows a half-updated value.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | nothing queued
// WAIT_VB | work queued, waiting for vblank
// APPLY   | one action per vblank cycle (the pending result goes first)
module controlador_buffer_pantalla #(
    parameter int DIGITS     = 10,
    parameter int FIFO_DEPTH = 4,
    parameter int KEY_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  key_valid,
    input  logic [KEY_W-1:0]      key_code,
    output logic                  key_ready,
    input  logic                  result_valid,
    input  logic [4*DIGITS-1:0]   result,
    input  logic                  vblank,
    output logic [4*DIGITS-1:0]   numeros,
    output logic [3:0]            digit_count,
    output logic                  overflow,
    output logic                  busy
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    localparam logic [KEY_W-1:0] CODE_BORRAR = KEY_W'(21);
    localparam logic [KEY_W-1:0] CODE_AC     = KEY_W'(23);
    localparam logic [KEY_W-1:0] CODE_HEX_LIM = KEY_W'(16);
    localparam logic [3:0]       DIGITS_C    = 4'(DIGITS);

    typedef enum logic [1:0] {IDLE, WAIT_VB, APPLY} state_t;

    state_t             state;
    logic [KEY_W-1:0]   mem [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr;
    logic [PW-1:0]      rd_ptr;
    logic [CW-1:0]      fifo_cnt;
    logic [CW-1:0]      cnt_next;
    logic [W-1:0]       pending_result;
    logic               pending;
    logic               result_shown;
    logic               fifo_empty;
    logic               push;
    logic               pop;
    logic               act;
    logic               take_result;
    logic               work_after;
    logic [KEY_W-1:0]   head;

    assign fifo_empty  = (fifo_cnt == '0);
    assign key_ready   = (fifo_cnt != CW'(FIFO_DEPTH));
    assign push        = key_valid && key_ready;
    assign busy        = !fifo_empty || pending;
    assign act         = (state == APPLY) && vblank && busy;
    assign take_result = act && pending;
    assign pop         = act && !pending && !fifo_empty;
    assign head        = mem[rd_ptr];
    assign cnt_next    = fifo_cnt + CW'(push) - CW'(pop);
    // Work still queued after this cycle's action, counting arrivals in the same cycle
    assign work_after  = (cnt_next != '0) || result_valid || (pending && !take_result);

    // Key event storage; contents need no reset because the pointers qualify them
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= key_code;
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop)  rd_ptr <= rd_ptr + PW'(1);
            fifo_cnt <= cnt_next;
        end
    end

    // Pending result: a new pulse wins over clearing, so a result that arrives
    // in the same cycle as an apply stays queued for the next blanking cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_result <= '0;
            pending        <= 1'b0;
        end else if (result_valid) begin
            pending_result <= result;
            pending        <= 1'b1;
        end else if (take_result) begin
            pending        <= 1'b0;
        end
    end

    // Sequencing FSM plus the display register updates it performs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            numeros      <= '0;
            digit_count  <= '0;
            overflow     <= 1'b0;
            result_shown <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (busy) state <= vblank ? APPLY : WAIT_VB;
                end
                WAIT_VB: begin
                    if (vblank) state <= APPLY;
                end
                APPLY: begin
                    if (!vblank) begin
                        state <= busy ? WAIT_VB : IDLE;
                    end else begin
                        state <= work_after ? APPLY : IDLE;
                        if (take_result) begin
                            numeros      <= pending_result;
                            digit_count  <= DIGITS_C;
                            result_shown <= 1'b1;
                        end else if (pop) begin
                            if (head < CODE_HEX_LIM) begin
                                if (result_shown) begin
                                    numeros      <= {{(W-4){1'b0}}, head[3:0]};
                                    digit_count  <= 4'd1;
                                    result_shown <= 1'b0;
                                end else if (digit_count < DIGITS_C) begin
                                    numeros     <= {numeros[W-5:0], head[3:0]};
                                    digit_count <= digit_count + 4'd1;
                                end else begin
                                    overflow <= 1'b1;
                                end
                            end else if (head == CODE_BORRAR) begin
                                numeros      <= numeros >> 4;
                                result_shown <= 1'b0;
                                if (digit_count != 4'd0) digit_count <= digit_count - 4'd1;
                            end else if (head == CODE_AC) begin
                                numeros      <= '0;
                                digit_count  <= 4'd0;
                                overflow     <= 1'b0;
                                result_shown <= 1'b0;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controlador_buffer_pantalla.sv
// Directed bench for controlador_buffer_pantalla. Inputs change on the falling
// edge and outputs are sampled on the falling edge.
module tb_controlador_buffer_pantalla;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        key_valid = 1'b0;
    logic [4:0]  key_code = '0;
    logic        key_ready;
    logic        result_valid = 1'b0;
    logic [39:0] result = '0;
    logic        vblank = 1'b1;
    logic [39:0] numeros;
    logic [3:0]  digit_count;
    logic        overflow;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [4:0] K_BORRAR = 5'd21;
    localparam logic [4:0] K_AC     = 5'd23;

    controlador_buffer_pantalla dut (
        .clk(clk), .rst_n(rst_n), .key_valid(key_valid), .key_code(key_code),
        .key_ready(key_ready), .result_valid(result_valid), .result(result),
        .vblank(vblank), .numeros(numeros), .digit_count(digit_count),
        .overflow(overflow), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic apply_reset();
        rst_n = 1'b0;
        key_valid = 1'b0;
        result_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Offers one key for one cycle once key_ready is seen; returns on the next falling edge
    task automatic push_key(input logic [4:0] c);
        int w = 0;
        while (!key_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!key_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL push_timeout: key_ready=%0b required 1", key_ready);
        end
        key_valid = 1'b1;
        key_code  = c;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int w = 0;
        while (busy && w < 50) begin
            @(negedge clk);
            w++;
        end
        n_tests++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_timeout: busy=%0b required 0", busy);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        n_tests++; if (numeros !== 40'h0) begin n_fail++; $display("FAIL rst_numeros: got %h required %h", numeros, 40'h0); end
        n_tests++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL rst_digit_count: got %0d required 0", digit_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL rst_overflow: got %0b required 0", overflow); end
        n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL rst_key_ready: got %0b required 1", key_ready); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %0b required 0", busy); end
    endtask

    // Keys 1,2,3 with vblank high; each lands two edges after its handshake
    task automatic test_entry_latency();
        logic [39:0] exp_seq [4];
        exp_seq[0] = 40'h0; exp_seq[1] = 40'h1; exp_seq[2] = 40'h12; exp_seq[3] = 40'h123;
        vblank = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            push_key(5'(i));
            n_tests++; if (numeros !== exp_seq[i-1]) begin n_fail++; $display("FAIL lat_t+0 key%0d: got %h required %h", i, numeros, exp_seq[i-1]); end
            @(negedge clk);
            n_tests++; if (numeros !== exp_seq[i-1]) begin n_fail++; $display("FAIL lat_t+1 key%0d: got %h required %h", i, numeros, exp_seq[i-1]); end
            @(negedge clk);
            n_tests++; if (numeros !== exp_seq[i]) begin n_fail++; $display("FAIL lat_t+2 key%0d: got %h required %h", i, numeros, exp_seq[i]); end
        end
        n_tests++; if (digit_count !== 4'd3) begin n_fail++; $display("FAIL entry_digit_count: got %0d required 3", digit_count); end
    endtask

    // Fill the FIFO outside blanking, then apply part of it in a short blanking window
    task automatic test_fifo_vblank();
        apply_reset();
        vblank = 1'b0;
        push_key(5'd4);
        push_key(5'd5);
        push_key(5'd6);
        push_key(5'd7);
        n_tests++; if (key_ready !== 1'b0) begin n_fail++; $display("FAIL full_key_ready: got %0b required 0", key_ready); end
        key_valid = 1'b1;
        key_code  = 5'd8;
        @(negedge clk);
        key_valid = 1'b0;
        n_tests++; if (numeros !== 40'h0) begin n_fail++; $display("FAIL novb_numeros: got %h required %h", numeros, 40'h0); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL novb_busy: got %0b required 1", busy); end
        // first blanking edge moves WAIT_VB to APPLY, the next two each apply one key
        vblank = 1'b1;
        repeat (3) @(negedge clk);
        vblank = 1'b0;
        n_tests++; if (numeros !== 40'h45) begin n_fail++; $display("FAIL partial_numeros: got %h required %h", numeros, 40'h45); end
        n_tests++; if (digit_count !== 4'd2) begin n_fail++; $display("FAIL partial_digit_count: got %0d required 2", digit_count); end
        n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL partial_key_ready: got %0b required 1", key_ready); end
        repeat (3) @(negedge clk);
        n_tests++; if (numeros !== 40'h45) begin n_fail++; $display("FAIL hold_numeros: got %h required %h", numeros, 40'h45); end
        vblank = 1'b1;
        wait_idle();
        n_tests++; if (numeros !== 40'h4567) begin n_fail++; $display("FAIL rest_numeros: got %h required %h", numeros, 40'h4567); end
        n_tests++; if (digit_count !== 4'd4) begin n_fail++; $display("FAIL rest_digit_count: got %0d required 4", digit_count); end
    endtask

    task automatic test_overflow_ac();
        vblank = 1'b1;
        push_key(K_AC);
        wait_idle();
        for (int i = 0; i < 11; i++) push_key(5'hA);
        wait_idle();
        n_tests++; if (numeros !== 40'hAAAAAAAAAA) begin n_fail++; $display("FAIL ovf_numeros: got %h required %h", numeros, 40'hAAAAAAAAAA); end
        n_tests++; if (digit_count !== 4'd10) begin n_fail++; $display("FAIL ovf_digit_count: got %0d required 10", digit_count); end
        n_tests++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %0b required 1", overflow); end
        push_key(K_AC);
        wait_idle();
        n_tests++; if (numeros !== 40'h0) begin n_fail++; $display("FAIL ac_numeros: got %h required %h", numeros, 40'h0); end
        n_tests++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL ac_digit_count: got %0d required 0", digit_count); end
        n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL ac_overflow: got %0b required 0", overflow); end
    endtask

    task automatic test_borrar();
        logic [39:0] exp_n [5];
        logic [3:0]  exp_c [5];
        exp_n[0] = 40'h123; exp_n[1] = 40'h12; exp_n[2] = 40'h1; exp_n[3] = 40'h0; exp_n[4] = 40'h0;
        exp_c[0] = 4'd3; exp_c[1] = 4'd2; exp_c[2] = 4'd1; exp_c[3] = 4'd0; exp_c[4] = 4'd0;
        push_key(5'd1); push_key(5'd2); push_key(5'd3); push_key(5'd4);
        wait_idle();
        n_tests++; if (numeros !== 40'h1234) begin n_fail++; $display("FAIL bs_start: got %h required %h", numeros, 40'h1234); end
        for (int i = 0; i < 5; i++) begin
            push_key(K_BORRAR);
            wait_idle();
            n_tests++; if (numeros !== exp_n[i]) begin n_fail++; $display("FAIL bs%0d_numeros: got %h required %h", i, numeros, exp_n[i]); end
            n_tests++; if (digit_count !== exp_c[i]) begin n_fail++; $display("FAIL bs%0d_digit_count: got %0d required %0d", i, digit_count, exp_c[i]); end
        end
    endtask

    // Result queued behind two keys still goes first; following digit restarts entry
    task automatic test_result_priority();
        vblank = 1'b0;
        push_key(5'd7);
        push_key(5'd8);
        result_valid = 1'b1;
        result = 40'h00000000FF;
        @(negedge clk);
        result_valid = 1'b0;
        vblank = 1'b1;
        @(negedge clk);
        n_tests++; if (numeros !== 40'h0) begin n_fail++; $display("FAIL prio_enter: got %h required %h", numeros, 40'h0); end
        @(negedge clk);
        n_tests++; if (numeros !== 40'hFF) begin n_fail++; $display("FAIL prio_result: got %h required %h", numeros, 40'hFF); end
        n_tests++; if (digit_count !== 4'd10) begin n_fail++; $display("FAIL prio_result_count: got %0d required 10", digit_count); end
        @(negedge clk);
        n_tests++; if (numeros !== 40'h7) begin n_fail++; $display("FAIL prio_key7: got %h required %h", numeros, 40'h7); end
        n_tests++; if (digit_count !== 4'd1) begin n_fail++; $display("FAIL prio_key7_count: got %0d required 1", digit_count); end
        @(negedge clk);
        n_tests++; if (numeros !== 40'h78) begin n_fail++; $display("FAIL prio_key8: got %h required %h", numeros, 40'h78); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_busy: got %0b required 0", busy); end
    endtask

    task automatic test_result_overwrite();
        vblank = 1'b0;
        result_valid = 1'b1; result = 40'h111;
        @(negedge clk);
        result = 40'h222;
        @(negedge clk);
        result_valid = 1'b0;
        vblank = 1'b1;
        wait_idle();
        n_tests++; if (numeros !== 40'h222) begin n_fail++; $display("FAIL overwrite_numeros: got %h required %h", numeros, 40'h222); end
        n_tests++; if (digit_count !== 4'd10) begin n_fail++; $display("FAIL overwrite_count: got %0d required 10", digit_count); end
    endtask

    // New pulse coinciding with the apply of the previous result is shown one cycle later
    task automatic test_back_to_back_result();
        vblank = 1'b1;
        result_valid = 1'b1; result = 40'hAB;
        @(negedge clk);
        result_valid = 1'b0;
        @(negedge clk);
        result_valid = 1'b1; result = 40'hCD;
        @(negedge clk);
        result_valid = 1'b0;
        n_tests++; if (numeros !== 40'hAB) begin n_fail++; $display("FAIL b2b_first: got %h required %h", numeros, 40'hAB); end
        n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy: got %0b required 1", busy); end
        @(negedge clk);
        n_tests++; if (numeros !== 40'hCD) begin n_fail++; $display("FAIL b2b_second: got %h required %h", numeros, 40'hCD); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle: got %0b required 0", busy); end
    endtask

    task automatic test_reset_mid_apply();
        vblank = 1'b0;
        push_key(5'd1); push_key(5'd2); push_key(5'd3);
        result_valid = 1'b1; result = 40'h99;
        @(negedge clk);
        result_valid = 1'b0;
        vblank = 1'b1;
        @(negedge clk);
        @(negedge clk);
        n_tests++; if (numeros !== 40'h99) begin n_fail++; $display("FAIL mid_pre: got %h required %h", numeros, 40'h99); end
        #1 rst_n = 1'b0;
        #1;
        n_tests++; if (numeros !== 40'h0) begin n_fail++; $display("FAIL mid_numeros: got %h required %h", numeros, 40'h0); end
        n_tests++; if (digit_count !== 4'd0) begin n_fail++; $display("FAIL mid_digit_count: got %0d required 0", digit_count); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_busy: got %0b required 0", busy); end
        n_tests++; if (key_ready !== 1'b1) begin n_fail++; $display("FAIL mid_key_ready: got %0b required 1", key_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        n_tests++; if (numeros !== 40'h0) begin n_fail++; $display("FAIL post_numeros: got %h required %h", numeros, 40'h0); end
        n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL post_busy: got %0b required 0", busy); end
    endtask

    initial begin
        test_reset();
        test_entry_latency();
        test_fifo_vblank();
        test_overflow_ac();
        test_borrar();
        test_result_priority();
        test_result_overwrite();
        test_back_to_back_result();
        test_reset_mid_apply();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
